control_sequencer: RTL and testbench

// Instruction-level control FSM directly upstream of the datapath: drives every datapath strobe
// (Rin/Rout, PCin/PCout, IRin, Yin, Zin, MARin, MDRin/MDRout, HIin/HIout, LOin/LOout, IncPC,

---
 rtl/control_sequencer.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer
//   Instruction-level control FSM sitting directly upstream of the datapath.
//   Walks every instruction through fetch/decode/execute T-states and drives
//   all datapath strobes as Moore outputs of the state register plus the
//   op/Ra/Rb/Rc fields latched from the IR at the end of fetch.
//   Memory reads/writes wait on mem_ready with a bounded wait counter.
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-low reset
//   ir         in   [31:0] IR contents: op=[31:27] Ra=[26:23] Rb=[22:19] Rc=[18:15]
//   mem_ready  in   memory completed the current Read/Write this cycle
//   stop       in   idle at the next instruction boundary
//   rin_sel    out  [15:0] one-hot register load strobes
//   rout_sel   out  [15:0] one-hot register bus-drive strobes
//   PCin..Cout out  single-bit datapath strobes
//   alu_op     out  [2:0] 0 NONE 1 ADD 2 SUB 3 AND 4 OR 5 MUL
//   run        out  high unless idle, halted or in reset
//   mem_err    out  sticky memory wait timeout flag
module control_sequencer #(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   input  logic        stop,
   output logic [15:0] rin_sel,
   output logic [15:0] rout_sel,
   output logic        PCin,
   output logic        PCout,
   output logic        IRin,
   output logic        Yin,
   output logic        Zin,
   output logic        MARin,
   output logic        MDRin,
   output logic        MDRout,
   output logic        HIin,
   output logic        HIout,
   output logic        LOin,
   output logic        LOout,
   output logic        IncPC,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        Read,
   output logic        Write,
   output logic        Cout,
   output logic [2:0]  alu_op,
   output logic        run,
   output logic        mem_err
);

   localparam int unsigned CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

   typedef enum logic [3:0] {
      S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_IDLE, S_HALT
   } state_e;

   typedef enum logic [4:0] {
      OP_LD   = 5'b00000,
      OP_ST   = 5'b00010,
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_AND  = 5'b00101,
      OP_OR   = 5'b00110,
      OP_ADDI = 5'b01100,
      OP_MUL  = 5'b01111,
      OP_NOP  = 5'b11010,
      OP_HALT = 5'b11011
   } op_e;

   typedef enum logic [2:0] {
      ALU_NONE = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4,
      ALU_MUL  = 3'd5
   } alu_e;

   state_e        state, state_n;
   logic [4:0]    op_q;
   logic [3:0]    ra_q, rb_q, rc_q;
   logic [CW-1:0] wait_cnt, wait_cnt_n;
   logic          mem_err_q, mem_err_n;
   logic          in_wait, next_is_wait, timeout, end_instr;

   // Immediate field is consumed by the datapath, not by the sequencer.
   logic unused_imm;
   assign unused_imm = ^ir[14:0];

   function automatic logic is_alu(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   function automatic logic is_wait(input state_e s, input logic [4:0] op);
      return (s == S_T1) || ((s == S_T6) && (op == OP_LD)) || ((s == S_T7) && (op == OP_ST));
   endfunction

   // ------------------------------------------------------------------
   // State and latched instruction fields
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= S_RESET;
         op_q      <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         rc_q      <= '0;
         wait_cnt  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state     <= state_n;
         wait_cnt  <= wait_cnt_n;
         mem_err_q <= mem_err_n;
         if (state == S_T2) begin
            op_q <= ir[31:27];
            ra_q <= ir[26:23];
            rb_q <= ir[22:19];
            rc_q <= ir[18:15];
         end
      end
   end

   // ------------------------------------------------------------------
   // Next state, wait counter, error flag
   // ------------------------------------------------------------------
   always_comb begin
      state_n      = state;
      wait_cnt_n   = wait_cnt;
      mem_err_n    = mem_err_q;
      end_instr    = 1'b0;
      in_wait      = is_wait(state, op_q);
      timeout      = in_wait && !mem_ready && (wait_cnt == CW'(WAIT_MAX));

      unique case (state)
         S_RESET: state_n = S_T0;
         S_T0:    state_n = S_T1;
         S_T1:    if (mem_ready) state_n = S_T2;
         S_T2: begin
            // Decode straight from ir: the fields are only latched on this exit.
            unique case (ir[31:27])
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST, OP_MUL:
                  state_n = S_T3;
               OP_NOP:  end_instr = 1'b1;
               default: state_n = S_HALT;
            endcase
         end
         S_T3: state_n = S_T4;
         S_T4: state_n = S_T5;
         S_T5: begin
            if (is_alu(op_q) || (op_q == OP_ADDI)) end_instr = 1'b1;
            else                                   state_n   = S_T6;
         end
         S_T6: begin
            unique case (op_q)
               OP_LD:   if (mem_ready) state_n = S_T7;
               OP_ST:   state_n   = S_T7;
               OP_MUL:  end_instr = 1'b1;
               default: state_n   = S_HALT;
            endcase
         end
         S_T7: begin
            unique case (op_q)
               OP_LD:   end_instr = 1'b1;
               OP_ST:   if (mem_ready) end_instr = 1'b1;
               default: state_n = S_HALT;
            endcase
         end
         S_IDLE: if (!stop) state_n = S_T0;
         S_HALT: state_n = S_HALT;
         default: state_n = S_HALT;
      endcase

      if (end_instr)
         state_n = stop ? S_IDLE : S_T0;

      if (timeout) begin
         state_n   = S_HALT;
         mem_err_n = 1'b1;
      end else if (in_wait && !mem_ready) begin
         wait_cnt_n = wait_cnt + 1'b1;
      end

      next_is_wait = is_wait(state_n, op_q);
      if (next_is_wait && (state_n != state))
         wait_cnt_n = '0;
   end

   // ------------------------------------------------------------------
   // Moore output decode
   // ------------------------------------------------------------------
   always_comb begin
      rin_sel  = '0;
      rout_sel = '0;
      PCin     = 1'b0;
      PCout    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      MARin    = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      HIin     = 1'b0;
      HIout    = 1'b0;
      LOin     = 1'b0;
      LOout    = 1'b0;
      IncPC    = 1'b0;
      Zhighout = 1'b0;
      Zlowout  = 1'b0;
      Read     = 1'b0;
      Write    = 1'b0;
      Cout     = 1'b0;
      alu_op   = ALU_NONE;
      run      = !((state == S_RESET) || (state == S_IDLE) || (state == S_HALT));
      mem_err  = mem_err_q;

      unique case (state)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            rout_sel = (op_q == OP_MUL) ? (16'h0001 << ra_q) : (16'h0001 << rb_q);
            Yin      = 1'b1;
         end
         S_T4: begin
            Zin = 1'b1;
            if (op_q == OP_MUL) begin
               rout_sel = 16'h0001 << rb_q;
               alu_op   = ALU_MUL;
            end else if (is_alu(op_q)) begin
               rout_sel = 16'h0001 << rc_q;
               unique case (op_q)
                  OP_SUB:  alu_op = ALU_SUB;
                  OP_AND:  alu_op = ALU_AND;
                  OP_OR:   alu_op = ALU_OR;
                  default: alu_op = ALU_ADD;
               endcase
            end else begin
               Cout   = 1'b1;
               alu_op = ALU_ADD;
            end
         end
         S_T5: begin
            Zlowout = 1'b1;
            if (op_q == OP_MUL)                         LOin    = 1'b1;
            else if ((op_q == OP_LD) || (op_q == OP_ST)) MARin   = 1'b1;
            else                                        rin_sel = 16'h0001 << ra_q;
         end
         S_T6: begin
            unique case (op_q)
               OP_LD: begin
                  Read  = 1'b1;
                  MDRin = 1'b1;
               end
               OP_ST: begin
                  rout_sel = 16'h0001 << ra_q;
                  MDRin    = 1'b1;
               end
               OP_MUL: begin
                  Zhighout = 1'b1;
                  HIin     = 1'b1;
               end
               default: ;
            endcase
         end
         S_T7: begin
            if (op_q == OP_LD) begin
               MDRout  = 1'b1;
               rin_sel = 16'h0001 << ra_q;
            end else if (op_q == OP_ST) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Table-driven directed vectors for control_sequencer plus hand-written
//   sequences for memory timeout and mid-instruction reset.
module tb_control_sequencer;

   localparam int unsigned WAIT_MAX = 15;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] ir;
   logic        mem_ready;
   logic        stop;
   logic [15:0] rin_sel, rout_sel;
   logic        PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout, HIin, HIout;
   logic        LOin, LOout, IncPC, Zhighout, Zlowout, Read, Write, Cout;
   logic [2:0]  alu_op;
   logic        run, mem_err;

   control_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
      .rin_sel(rin_sel), .rout_sel(rout_sel),
      .PCin(PCin), .PCout(PCout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
      .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .HIin(HIin), .HIout(HIout),
      .LOin(LOin), .LOout(LOout), .IncPC(IncPC), .Zhighout(Zhighout),
      .Zlowout(Zlowout), .Read(Read), .Write(Write), .Cout(Cout),
      .alu_op(alu_op), .run(run), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   localparam logic [17:0] PCIN = 18'h20000, PCOUT = 18'h10000, IRIN = 18'h08000,
      YIN = 18'h04000, ZIN = 18'h02000, MARIN = 18'h01000, MDRIN = 18'h00800,
      MDROUT = 18'h00400, HIIN = 18'h00200, HIOUT = 18'h00100, LOIN = 18'h00080,
      LOOUT = 18'h00040, INCPC = 18'h00020, ZHIGHOUT = 18'h00010, ZLOWOUT = 18'h00008,
      READ = 18'h00004, WRITE = 18'h00002, COUT = 18'h00001;

   localparam logic [17:0] F0 = PCOUT | MARIN | INCPC | ZIN;
   localparam logic [17:0] F1 = ZLOWOUT | PCIN | READ | MDRIN;
   localparam logic [17:0] F2 = MDROUT | IRIN;

   localparam logic [31:0] I_ADD  = 32'h18918000;
   localparam logic [31:0] I_LD   = {5'b00000, 4'd4, 4'd2, 4'd0, 15'h0010};
   localparam logic [31:0] I_MUL  = {5'b01111, 4'd5, 4'd6, 4'd0, 15'h0000};
   localparam logic [31:0] I_ADDI = {5'b01100, 4'd7, 4'd1, 4'd0, 15'h0005};
   localparam logic [31:0] I_BAD  = {5'b11111, 27'd0};
   localparam logic [31:0] I_ST   = {5'b00010, 4'd8, 4'd9, 4'd0, 15'h0004};

   logic [54:0] act;
   assign act = {rin_sel, rout_sel, PCin, PCout, IRin, Yin, Zin, MARin, MDRin, MDRout,
                 HIin, HIout, LOin, LOout, IncPC, Zhighout, Zlowout, Read, Write, Cout,
                 alu_op, run, mem_err};

   typedef struct {
      logic        clr;
      logic [31:0] ir;
      logic        mr;
      logic        stop;
      logic [54:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   rin_pulses = 0;
   logic mon_en = 1'b0;

   always @(negedge clk)
      if (mon_en && (rin_sel != 16'h0000)) rin_pulses++;

   function automatic logic [54:0] e(input logic [15:0] rin, input logic [15:0] rout,
                                     input logic [17:0] s, input logic [2:0] alu,
                                     input logic r, input logic err);
      return {rin, rout, s, alu, r, err};
   endfunction

   task automatic v(input logic c, input logic [31:0] i, input logic mr, input logic st,
                    input logic [54:0] x);
      vec_t t;
      t.clr = c; t.ir = i; t.mr = mr; t.stop = st; t.exp = x;
      vecs.push_back(t);
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [54:0] x);
      n_checks++;
      if (act !== x) begin
         n_err++;
         $display("FAIL %s got %h want %h", name, act, x);
      end
   endtask

   initial begin
      int wcount;
      clr = 1'b0; ir = '0; mem_ready = 1'b1; stop = 1'b0;

      // add R1,R2,R3
      v(0, I_ADD, 1, 0, e(0, 0, 0, 0, 0, 0));
      v(1, I_ADD, 1, 0, e(0, 0, F0, 0, 1, 0));
      v(1, I_ADD, 1, 0, e(0, 0, F1, 0, 1, 0));
      v(1, I_ADD, 1, 0, e(0, 0, F2, 0, 1, 0));
      v(1, I_ADD, 1, 0, e(0, 16'h0004, YIN, 0, 1, 0));
      v(1, I_ADD, 1, 0, e(0, 16'h0008, ZIN, 3'd1, 1, 0));
      v(1, I_ADD, 1, 0, e(16'h0002, 0, ZLOWOUT, 0, 1, 0));
      // ld R4,0x10(R2), mem_ready low 3 cycles in T6
      v(1, I_LD, 1, 0, e(0, 0, F0, 0, 1, 0));
      v(1, I_LD, 1, 0, e(0, 0, F1, 0, 1, 0));
      v(1, I_LD, 1, 0, e(0, 0, F2, 0, 1, 0));
      v(1, I_LD, 1, 0, e(0, 16'h0004, YIN, 0, 1, 0));
      v(1, I_LD, 1, 0, e(0, 0, COUT | ZIN, 3'd1, 1, 0));
      v(1, I_LD, 1, 0, e(0, 0, ZLOWOUT | MARIN, 0, 1, 0));
      v(1, I_LD, 1, 0, e(0, 0, READ | MDRIN, 0, 1, 0));
      v(1, I_LD, 0, 0, e(0, 0, READ | MDRIN, 0, 1, 0));
      v(1, I_LD, 0, 0, e(0, 0, READ | MDRIN, 0, 1, 0));
      v(1, I_LD, 0, 0, e(0, 0, READ | MDRIN, 0, 1, 0));
      v(1, I_LD, 1, 0, e(16'h0010, 0, MDROUT, 0, 1, 0));
      // mul R5,R6 with one fetch wait cycle in T1
      v(1, I_MUL, 1, 0, e(0, 0, F0, 0, 1, 0));
      v(1, I_MUL, 1, 0, e(0, 0, F1, 0, 1, 0));
      v(1, I_MUL, 0, 0, e(0, 0, F1, 0, 1, 0));
      v(1, I_MUL, 1, 0, e(0, 0, F2, 0, 1, 0));
      v(1, I_MUL, 1, 0, e(0, 16'h0020, YIN, 0, 1, 0));
      v(1, I_MUL, 1, 0, e(0, 16'h0040, ZIN, 3'd5, 1, 0));
      v(1, I_MUL, 1, 0, e(0, 0, ZLOWOUT | LOIN, 0, 1, 0));
      v(1, I_MUL, 1, 0, e(0, 0, ZHIGHOUT | HIIN, 0, 1, 0));
      // addi R7,R1,5 with stop raised mid-execute
      v(1, I_ADDI, 1, 0, e(0, 0, F0, 0, 1, 0));
      v(1, I_ADDI, 1, 0, e(0, 0, F1, 0, 1, 0));
      v(1, I_ADDI, 1, 0, e(0, 0, F2, 0, 1, 0));
      v(1, I_ADDI, 1, 0, e(0, 16'h0002, YIN, 0, 1, 0));
      v(1, I_ADDI, 1, 1, e(0, 0, COUT | ZIN, 3'd1, 1, 0));
      v(1, I_ADDI, 1, 1, e(16'h0080, 0, ZLOWOUT, 0, 1, 0));
      v(1, I_ADDI, 1, 1, e(0, 0, 0, 0, 0, 0));
      v(1, I_ADDI, 1, 1, e(0, 0, 0, 0, 0, 0));
      // illegal op 11111
      v(1, I_BAD, 1, 0, e(0, 0, F0, 0, 1, 0));
      v(1, I_BAD, 1, 0, e(0, 0, F1, 0, 1, 0));
      v(1, I_BAD, 1, 0, e(0, 0, F2, 0, 1, 0));
      v(1, I_BAD, 1, 0, e(0, 0, 0, 0, 0, 0));
      v(1, I_BAD, 1, 0, e(0, 0, 0, 0, 0, 0));
      v(1, I_ADD, 1, 0, e(0, 0, 0, 0, 0, 0));

      foreach (vecs[k]) begin
         clr = vecs[k].clr; ir = vecs[k].ir; mem_ready = vecs[k].mr; stop = vecs[k].stop;
         tick();
         chk($sformatf("vec%0d", k), vecs[k].exp);
      end

      // ld wait to exactly WAIT_MAX, then st that never completes
      clr = 1'b0; mem_ready = 1'b1; stop = 1'b0; ir = I_LD;
      tick();
      chk("rst2", e(0, 0, 0, 0, 0, 0));
      clr = 1'b1;
      repeat (7) tick();
      chk("ld_t6", e(0, 0, READ | MDRIN, 0, 1, 0));
      mem_ready = 1'b0;
      repeat (WAIT_MAX) tick();
      chk("ld_wait_max", e(0, 0, READ | MDRIN, 0, 1, 0));
      mem_ready = 1'b1;
      tick();
      chk("ld_late_ok", e(16'h0010, 0, MDROUT, 0, 1, 0));
      ir = I_ST;
      repeat (4) tick();
      chk("st_t3", e(0, 16'h0200, YIN, 0, 1, 0));
      repeat (3) tick();
      chk("st_t6", e(0, 16'h0100, MDRIN, 0, 1, 0));
      mem_ready = 1'b0;
      tick();
      wcount = 0;
      for (int i = 0; i < 40; i++) begin
         if (!Write) break;
         wcount++;
         tick();
      end
      n_checks++;
      if (wcount != WAIT_MAX + 1) begin
         n_err++;
         $display("FAIL st_write_len got %0d want %0d", wcount, WAIT_MAX + 1);
      end
      chk("st_timeout_halt", e(0, 0, 0, 0, 0, 1));
      mem_ready = 1'b1;
      tick();
      chk("halt_sticky", e(0, 0, 0, 0, 0, 1));

      // reset in T4 of add aborts the instruction
      clr = 1'b0; ir = I_ADD;
      tick();
      chk("rst3", e(0, 0, 0, 0, 0, 0));
      clr = 1'b1;
      repeat (5) tick();
      chk("abort_t4", e(0, 16'h0008, ZIN, 3'd1, 1, 0));
      mon_en = 1'b1;
      clr = 1'b0;
      #1;
      chk("abort_async", e(0, 0, 0, 0, 0, 0));
      tick();
      chk("abort_hold", e(0, 0, 0, 0, 0, 0));
      clr = 1'b1;
      tick();
      chk("abort_restart_t0", e(0, 0, F0, 0, 1, 0));
      tick();
      chk("abort_t1", e(0, 0, F1, 0, 1, 0));
      mon_en = 1'b0;
      n_checks++;
      if (rin_pulses != 0) begin
         n_err++;
         $display("FAIL abort_rin got %0d pulses want 0", rin_pulses);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
